// File: rtl/mul5_pkg.sv
// mul5_pkg: shared FSM state type and default multiplier latency for mul5_arb_ctrl
package mul5_pkg;
    localparam int MUL_LAT_DEF = 6;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/mul5_arb_ctrl_if.sv
// mul5_arb_ctrl_if: requester, response and multiplier signals of mul5_arb_ctrl
// slave = controller view, master = environment view (requesters, consumer, multiplier)
interface mul5_arb_ctrl_if;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [9:0] rsp_p;
    logic [4:0] mul_a, mul_b;
    logic       mul_en;
    logic [9:0] mul_p;
    logic       busy;
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready, mul_p,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, mul_a, mul_b, mul_en, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready, mul_p,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_p, mul_a, mul_b, mul_en, busy
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
// req_i: request vector, last_i: index granted last time, gnt_o: one-hot grant
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);
    assign gnt_o[0] = req_i[0] & (~req_i[1] | last_i);
    assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_i);
endmodule

// File: rtl/mul5_arb_ctrl.sv
// mul5_arb_ctrl: arbitrates two requesters onto one external pipelined 5x5 multiplier
// clk: clock, rst_n: sync active-high reset, bus: requester/response/multiplier signals
module mul5_arb_ctrl
    import mul5_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mul5_arb_ctrl_if.slave bus
);
    localparam int CW = $clog2(MUL_LAT + 1);
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_q, id_q, idle;
    logic [4:0]    a_q, b_q;
    logic [9:0]    p_q;
    logic [1:0]    gnt;
    rr_arb2 u_arb (
        .req_i  ({bus.req1_valid, bus.req0_valid}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );
    // ready is held low during reset even before the state register has settled
    assign idle           = (state_q == IDLE) & ~rst_n;
    assign bus.req0_ready = idle & gnt[0];
    assign bus.req1_ready = idle & gnt[1];
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.mul_en     = state_q == BUSY;
    assign bus.busy       = state_q != IDLE;
    assign bus.rsp_valid  = state_q == DONE;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_p      = p_q;
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    a_q     <= gnt[1] ? bus.req1_a : bus.req0_a;
                    b_q     <= gnt[1] ? bus.req1_b : bus.req0_b;
                    id_q    <= gnt[1];
                    last_q  <= gnt[1];
                    cnt_q   <= '0;
                    state_q <= BUSY;
                end
                // capture one edge after the counter reaches MUL_LAT, so the product
                // sampled here is MUL_LAT+1 edges after the operands were driven
                BUSY: if (cnt_q == CW'(MUL_LAT)) begin
                    p_q     <= bus.mul_p;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: if (bus.rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul5_arb_ctrl.sv
// tb_mul5_arb_ctrl: directed and randomized checks of mul5_arb_ctrl against a transaction model
module tb_mul5_arb_ctrl;
    localparam int LAT = 6;
    logic clk = 0;
    always #5 clk = ~clk;
    logic       rst_n = 1, v0 = 0, v1 = 0, rsp_ready = 1;
    logic [4:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    mul5_arb_ctrl_if ifc ();
    assign ifc.req0_valid = v0;
    assign ifc.req1_valid = v1;
    assign ifc.req0_a     = a0;
    assign ifc.req0_b     = b0;
    assign ifc.req1_a     = a1;
    assign ifc.req1_b     = b1;
    assign ifc.rsp_ready  = rsp_ready;
    mul5_arb_ctrl #(.MUL_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    // external multiplier: product of the operands seen at an edge appears LAT edges later
    logic [9:0] pipe [LAT];
    assign ifc.mul_p = pipe[LAT-1];
    always @(posedge clk) begin
        pipe[0] <= 10'(ifc.mul_a * ifc.mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    int n_chk = 0, n_fail = 0, cyc = 0;
    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask
    // transaction model: phase 0 idle, 1 computing (k edges since handshake), 2 holding result
    int ph = 0, k = 0, m_a = 0, m_b = 0, m_p = 0, m_id = 0, m_last = 1;
    bit started = 0;
    function automatic int pick(logic x0, logic x1, int last);
        if (x0 && x1) return (last == 0) ? 1 : 0;
        if (x0) return 0;
        if (x1) return 1;
        return -1;
    endfunction
    always @(posedge clk) begin : model
        int g;
        cyc++;
        started = 1;
        if (rst_n) begin
            ph = 0; k = 0; m_a = 0; m_b = 0; m_p = 0; m_id = 0; m_last = 1;
        end else if (ph == 0) begin
            g = pick(v0, v1, m_last);
            if (g >= 0) begin
                m_a = (g == 1) ? int'(a1) : int'(a0);
                m_b = (g == 1) ? int'(b1) : int'(b0);
                m_id = g; m_last = g; ph = 1; k = 0;
            end
        end else if (ph == 1) begin
            k++;
            if (k == LAT + 1) begin ph = 2; m_p = m_a * m_b; end
        end else if (rsp_ready) begin
            ph = 0;
        end
    end
    always @(negedge clk) begin : compare
        int g;
        if (started) begin
            g = (!rst_n && ph == 0) ? pick(v0, v1, m_last) : -1;
            chk("req0_ready", ifc.req0_ready, int'(g == 0));
            chk("req1_ready", ifc.req1_ready, int'(g == 1));
            chk("busy", ifc.busy, int'(ph != 0));
            chk("mul_en", ifc.mul_en, int'(ph == 1));
            chk("rsp_valid", ifc.rsp_valid, int'(ph == 2));
            chk("mul_a", ifc.mul_a, m_a);
            chk("mul_b", ifc.mul_b, m_b);
            if (ph == 2 || rst_n) begin
                chk("rsp_p", ifc.rsp_p, m_p);
                chk("rsp_id", ifc.rsp_id, m_id);
            end
        end
    end
    bit h0, h1;
    int keep0 = 0, keep1 = 0, rnd = 0;
    int rp[$], ri[$];
    function automatic int at(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction
    task automatic tick();
        bit x0, x1;
        #1;
        x0 = v0 && ifc.req0_ready;
        x1 = v1 && ifc.req1_ready;
        if (ifc.rsp_valid && rsp_ready && !rst_n) begin
            rp.push_back(int'(ifc.rsp_p));
            ri.push_back(int'(ifc.rsp_id));
        end
        @(posedge clk);
        #1;
        h0 = x0;
        h1 = x1;
        if (x0) begin
            if (keep0 != 0) begin a0 = 5'($urandom_range(0, 31)); b0 = 5'($urandom_range(0, 31)); end
            else v0 = 0;
        end
        if (x1) begin
            if (keep1 != 0) begin a1 = 5'($urandom_range(0, 31)); b1 = 5'($urandom_range(0, 31)); end
            else v1 = 0;
        end
        if (rnd != 0) begin
            if (!v0 && $urandom_range(0, 2) == 0) begin v0 = 1; a0 = 5'($urandom_range(0, 31)); b0 = 5'($urandom_range(0, 31)); end
            if (!v1 && $urandom_range(0, 2) == 0) begin v1 = 1; a1 = 5'($urandom_range(0, 31)); b1 = 5'($urandom_range(0, 31)); end
            rsp_ready = $urandom_range(0, 3) != 0;
        end
        #1;
    endtask
    task automatic wait_hs(int id);
        int n = 0;
        do begin tick(); n++; end while (!(id == 1 ? h1 : h0) && n < 50);
        chk("handshake", int'(id == 1 ? h1 : h0), 1);
    endtask
    task automatic wait_rsp();
        int n = 0;
        while (!ifc.rsp_valid && n < 40) begin tick(); n++; end
        chk("rsp_arrives", ifc.rsp_valid, 1);
    endtask
    task automatic drain();
        int n = 0;
        rsp_ready = 1;
        while ((v0 || v1 || ifc.busy) && n < 200) begin tick(); n++; end
        chk("drain", ifc.busy, 0);
    endtask
    initial begin
        int lat, seen;
        // reset with a requester already valid: ready must stay low
        v0 = 1; a0 = 5; b0 = 5;
        repeat (3) tick();
        chk("rst_ready0", ifc.req0_ready, 0);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_mul_a", ifc.mul_a, 0);
        v0 = 0; rst_n = 0;
        tick();
        // 31*31 latency and product
        v0 = 1; a0 = 31; b0 = 31;
        wait_hs(0);
        lat = 0;
        while (!ifc.rsp_valid && lat < 30) begin tick(); lat++; end
        chk("latency", lat, 7);
        chk("p_31x31", ifc.rsp_p, 961);
        chk("id_31x31", ifc.rsp_id, 0);
        tick();
        // simultaneous requests straight after reset: requester 0 first
        rst_n = 1; repeat (2) tick();
        v0 = 1; a0 = 3; b0 = 5; v1 = 1; a1 = 7; b1 = 9;
        rst_n = 0;
        rp.delete(); ri.delete();
        lat = 0;
        while (rp.size() < 2 && lat < 60) begin tick(); lat++; end
        chk("contend_p0", at(rp, 0), 15);
        chk("contend_id0", at(ri, 0), 0);
        chk("contend_p1", at(rp, 1), 63);
        chk("contend_id1", at(ri, 1), 1);
        drain();
        // consumer stalls 10 cycles while another request waits
        rsp_ready = 0;
        v1 = 1; a1 = 6; b1 = 7;
        wait_hs(1);
        v0 = 1; a0 = 1; b0 = 1;
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("stall_p", ifc.rsp_p, 42);
            chk("stall_valid", ifc.rsp_valid, 1);
            chk("stall_ready0", ifc.req0_ready, 0);
            chk("stall_ready1", ifc.req1_ready, 0);
            tick();
        end
        rp.delete(); ri.delete();
        rsp_ready = 1;
        tick();
        chk("stall_count", rp.size(), 1);
        chk("stall_rsp", at(rp, 0), 42);
        chk("stall_valid_drop", ifc.rsp_valid, 0);
        drain();
        // operand changes while busy must not reach the multiplier
        v0 = 1; a0 = 0; b0 = 17;
        wait_hs(0);
        a0 = 31; b0 = 31; v1 = 1; a1 = 3; b1 = 3;
        for (int i = 0; i < 4; i++) begin
            chk("hold_mul_a", ifc.mul_a, 0);
            chk("hold_mul_b", ifc.mul_b, 17);
            tick();
        end
        wait_rsp();
        chk("hold_p", ifc.rsp_p, 0);
        chk("hold_id", ifc.rsp_id, 0);
        drain();
        // reset while the counter is at 3
        v0 = 1; a0 = 9; b0 = 9;
        wait_hs(0);
        repeat (3) tick();
        rst_n = 1; v1 = 1;
        tick();
        chk("abort_valid", ifc.rsp_valid, 0);
        chk("abort_busy", ifc.busy, 0);
        chk("abort_en", ifc.mul_en, 0);
        chk("abort_mul_a", ifc.mul_a, 0);
        chk("abort_mul_b", ifc.mul_b, 0);
        chk("abort_p", ifc.rsp_p, 0);
        chk("abort_id", ifc.rsp_id, 0);
        chk("abort_ready1", ifc.req1_ready, 0);
        v1 = 0;
        tick();
        rst_n = 0;
        seen = 0;
        repeat (10) begin tick(); if (ifc.rsp_valid) seen++; end
        chk("abort_no_rsp", seen, 0);
        v0 = 1; a0 = 2; b0 = 2;
        wait_hs(0);
        wait_rsp();
        chk("after_abort_p", ifc.rsp_p, 4);
        drain();
        // continuous requests from both: strict alternation
        keep0 = 1; keep1 = 1;
        v0 = 1; a0 = 5'($urandom_range(0, 31)); b0 = 5'($urandom_range(0, 31));
        v1 = 1; a1 = 5'($urandom_range(0, 31)); b1 = 5'($urandom_range(0, 31));
        rp.delete(); ri.delete();
        repeat (80) tick();
        keep0 = 0; keep1 = 0;
        drain();
        chk("b2b_count", int'(ri.size() >= 8), 1);
        for (int i = 1; i < ri.size(); i++) chk("b2b_alternate", ri[i], 1 - ri[i-1]);
        // random traffic, stalls and occasional resets
        rnd = 1;
        repeat (500) begin
            rst_n = ($urandom_range(0, 149) == 0);
            tick();
        end
        rnd = 0; rst_n = 0;
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
